// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA display blocks.
// Span helpers derive line/frame totals from porch and sync widths.
package vga_pkg;

    typedef logic [11:0] rgb12_t;

    // Control bits that travel alongside a pixel through the fetch latency.
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic act;
        logic hit;
    } vga_ctl_t;

    localparam vga_ctl_t CTL_IDLE = '{
        hs_n: 1'b1,
        vs_n: 1'b1,
        act:  1'b0,
        hit:  1'b0
    };

    localparam int DEF_H_ACT   = 640;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_V_ACT   = 480;
    localparam int DEF_V_FRONT = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 33;

    function automatic int span_total(
        input int act,
        input int front,
        input int sync,
        input int back
    );
        return act + front + sync + back;
    endfunction

    function automatic int span_blank(
        input int front,
        input int sync,
        input int back
    );
        return front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running x/y raster counters with raw sync, active and frame flags.
// Sync sits at the start of each span, the active region at the end.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACT   = DEF_H_ACT,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int V_ACT   = DEF_V_ACT,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    localparam int H_TOTAL = span_total(H_ACT, H_FRONT, H_SYNC, H_BACK),
    localparam int V_TOTAL = span_total(V_ACT, V_FRONT, V_SYNC, V_BACK),
    localparam int XW = $clog2(H_TOTAL),
    localparam int YW = $clog2(V_TOTAL)
) (
    input  logic          i_clk_25M,
    input  logic          i_rst_n,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_hs_n,
    output logic          o_vs_n,
    output logic          o_active,
    output logic          o_frame_start
);

    localparam int H_BLANK = span_blank(H_FRONT, H_SYNC, H_BACK);
    localparam int V_BLANK = span_blank(V_FRONT, V_SYNC, V_BACK);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          started;

    // Hold at the origin for one cycle after reset, then scan the raster.
    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x       <= '0;
            y       <= '0;
            started <= 1'b0;
        end else if (!started) begin
            started <= 1'b1;
        end else if (x == XW'(H_TOTAL - 1)) begin
            x <= '0;
            if (y == YW'(V_TOTAL - 1)) begin
                y <= '0;
            end else begin
                y <= y + 1'b1;
            end
        end else begin
            x <= x + 1'b1;
        end
    end

    // Raw flags decoded from the counter state; idle until scanning starts.
    always_comb begin
        o_hs_n        = !(started && (x < XW'(H_SYNC)));
        o_vs_n        = !(started && (y < YW'(V_SYNC)));
        o_active      = started
                        && (x >= XW'(H_BLANK))
                        && (y >= YW'(V_BLANK));
        o_frame_start = started && (x == '0) && (y == '0);
    end

    assign o_x = x;
    assign o_y = y;

endmodule

// File: rtl/vga_sprite_gen.sv
// VGA raster generator compositing one movable sprite over a background.
// Fetch is issued from counter state; control is delayed to meet the pixel.
module vga_sprite_gen
    import vga_pkg::*;
#(
    parameter int     H_ACT     = DEF_H_ACT,
    parameter int     H_FRONT   = DEF_H_FRONT,
    parameter int     H_SYNC    = DEF_H_SYNC,
    parameter int     H_BACK    = DEF_H_BACK,
    parameter int     V_ACT     = DEF_V_ACT,
    parameter int     V_FRONT   = DEF_V_FRONT,
    parameter int     V_SYNC    = DEF_V_SYNC,
    parameter int     V_BACK    = DEF_V_BACK,
    parameter int     SPR_W     = 64,
    parameter int     SPR_H     = 64,
    parameter int     PIX_LAT   = 1,
    parameter rgb12_t KEY_COLOR = 12'hF0F,
    localparam int UW = $clog2(SPR_W),
    localparam int VW = $clog2(SPR_H)
) (
    input  logic          i_clk_25M,
    input  logic          i_rst_n,
    input  logic [9:0]    i_spr_x,
    input  logic [9:0]    i_spr_y,
    input  logic [11:0]   i_bg_rgb,
    input  logic [11:0]   i_spr_pix,
    output logic          o_spr_req,
    output logic [UW-1:0] o_spr_u,
    output logic [VW-1:0] o_spr_v,
    output logic          o_frame_start,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic          VGA_CLK
);

    localparam int H_BLANK = span_blank(H_FRONT, H_SYNC, H_BACK);
    localparam int V_BLANK = span_blank(V_FRONT, V_SYNC, V_BACK);
    localparam int XW = $clog2(span_total(H_ACT, H_FRONT, H_SYNC, H_BACK));
    localparam int YW = $clog2(span_total(V_ACT, V_FRONT, V_SYNC, V_BACK));

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          hs_n;
    logic          vs_n;
    logic          act;
    logic          frame_start;

    vga_timing_gen #(
        .H_ACT   (H_ACT),
        .H_FRONT (H_FRONT),
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .V_ACT   (V_ACT),
        .V_FRONT (V_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK)
    ) u_timing (
        .i_clk_25M     (i_clk_25M),
        .i_rst_n       (i_rst_n),
        .o_x           (x),
        .o_y           (y),
        .o_hs_n        (hs_n),
        .o_vs_n        (vs_n),
        .o_active      (act),
        .o_frame_start (frame_start)
    );

    assign o_frame_start = frame_start;

    logic [9:0] sx;
    logic [9:0] sy;

    // Latch the sprite position only at the frame origin so it never tears.
    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sx <= '0;
            sy <= '0;
        end else if (frame_start) begin
            sx <= i_spr_x;
            sy <= i_spr_y;
        end
    end

    logic [10:0] ax;
    logic [10:0] ay;
    logic [10:0] dx;
    logic [10:0] dy;
    logic        hit;

    // Window test; the spare top bit turns a negative offset into a miss.
    always_comb begin
        ax  = 11'(x) - 11'(H_BLANK);
        ay  = 11'(y) - 11'(V_BLANK);
        dx  = ax - {1'b0, sx};
        dy  = ay - {1'b0, sy};
        hit = act
              && (dx < 11'(SPR_W))
              && (dy < 11'(SPR_H));
    end

    // Fetch strobe and sprite-local address, zeroed on a miss.
    always_comb begin
        o_spr_req = hit;
        o_spr_u   = hit ? dx[UW-1:0] : '0;
        o_spr_v   = hit ? dy[VW-1:0] : '0;
    end

    vga_ctl_t cur;
    vga_ctl_t pipe [PIX_LAT];
    vga_ctl_t tail;

    assign cur  = '{hs_n: hs_n, vs_n: vs_n, act: act, hit: hit};
    assign tail = pipe[PIX_LAT-1];

    // Carry control bits for PIX_LAT cycles to meet the returning pixel.
    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < PIX_LAT; i++) begin
                pipe[i] <= CTL_IDLE;
            end
        end else begin
            pipe[0] <= cur;
            for (int i = 1; i < PIX_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    rgb12_t rgb_q;
    logic   hs_q;
    logic   vs_q;
    logic   bn_q;

    // Composite and register every pin in the same cycle.
    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            bn_q  <= 1'b0;
        end else begin
            hs_q <= tail.hs_n;
            vs_q <= tail.vs_n;
            bn_q <= tail.act;
            if (!tail.act) begin
                rgb_q <= '0;
            end else if (tail.hit && (i_spr_pix != KEY_COLOR)) begin
                rgb_q <= i_spr_pix;
            end else begin
                rgb_q <= i_bg_rgb;
            end
        end
    end

    assign VGA_R       = {rgb_q[11:8], 4'h0};
    assign VGA_G       = {rgb_q[7:4], 4'h0};
    assign VGA_B       = {rgb_q[3:0], 4'h0};
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = bn_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = i_clk_25M;

endmodule

// File: tb/tb_vga_sprite_gen.sv
// Directed bench for vga_sprite_gen on a reduced 40x28 raster.
// Two builds share inputs: fetch latency 1 and fetch latency 3.
module tb_vga_sprite_gen;

    localparam int HA = 32, HF = 2, HSY = 4, HBK = 2;
    localparam int VA = 24, VF = 1, VSY = 2, VBK = 1;
    localparam int HT = 40, HB = 8, VT = 28, VB = 4;
    localparam int FRAME = 1120;
    localparam logic [11:0] KEY = 12'hF0F;
    localparam logic [23:0] SPR_RGB = 24'h00F000;
    localparam logic [23:0] BG_RGB  = 24'h0000F0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  spr_x;
    logic [9:0]  spr_y;
    logic [11:0] bg;
    logic        rom_key;

    logic [11:0] pix1, pix3;
    logic        req1, req3;
    logic [2:0]  u1, v1, u3, v3;
    logic        fs1, fs3;
    logic [7:0]  r1, g1, b1, r3, g3, b3;
    logic        hs1, vs1, bn1, sn1, vc1;
    logic        hs3, vs3, bn3, sn3, vc3;

    int cyc;
    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #20 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [11:0] rom_f(input logic req);
        return req ? (rom_key ? KEY : 12'h0F0) : 12'h123;
    endfunction

    logic [11:0] q1;
    logic [11:0] q3 [3];

    always @(posedge clk) begin
        q1    <= rom_f(req1);
        q3[0] <= rom_f(req3);
        q3[1] <= q3[0];
        q3[2] <= q3[1];
    end

    assign pix1 = q1;
    assign pix3 = q3[2];

    vga_sprite_gen #(
        .H_ACT(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HBK),
        .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VBK),
        .SPR_W(8), .SPR_H(8), .PIX_LAT(1), .KEY_COLOR(KEY)
    ) dut1 (
        .i_clk_25M(clk), .i_rst_n(rst_n),
        .i_spr_x(spr_x), .i_spr_y(spr_y),
        .i_bg_rgb(bg), .i_spr_pix(pix1),
        .o_spr_req(req1), .o_spr_u(u1), .o_spr_v(v1),
        .o_frame_start(fs1),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
        .VGA_HS(hs1), .VGA_VS(vs1),
        .VGA_BLANK_N(bn1), .VGA_SYNC_N(sn1), .VGA_CLK(vc1)
    );

    vga_sprite_gen #(
        .H_ACT(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HBK),
        .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VBK),
        .SPR_W(8), .SPR_H(8), .PIX_LAT(3), .KEY_COLOR(KEY)
    ) dut3 (
        .i_clk_25M(clk), .i_rst_n(rst_n),
        .i_spr_x(spr_x), .i_spr_y(spr_y),
        .i_bg_rgb(bg), .i_spr_pix(pix3),
        .o_spr_req(req3), .o_spr_u(u3), .o_spr_v(v3),
        .o_frame_start(fs3),
        .VGA_R(r3), .VGA_G(g3), .VGA_B(b3),
        .VGA_HS(hs3), .VGA_VS(vs3),
        .VGA_BLANK_N(bn3), .VGA_SYNC_N(sn3), .VGA_CLK(vc3)
    );

    // off = cycles between counter state and the observed signals
    task automatic wait_at(input int ax, input int ay, input int off);
        int  tgt;
        int  n;
        bit  ok;
        tgt = (ay + VB) * HT + ax + HB;
        tgt = ((tgt % FRAME) + FRAME) % FRAME;
        ok  = 1'b0;
        n   = 0;
        while (!ok && n < 2 * FRAME + 8) begin
            @(negedge clk);
            n++;
            if (cyc - 1 - off >= 0 && (cyc - 1 - off) % FRAME == tgt)
                ok = 1'b1;
        end
        if (!ok) begin
            chk_cnt++;
            $display("FAIL wait_at(%0d,%0d): timeout after %0d cycles",
                     ax, ay, n);
        end
    endtask

    task automatic wait_fs;
        int n;
        bit ok;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < FRAME + 8) begin
            @(negedge clk);
            n++;
            if (fs1) ok = 1'b1;
        end
        if (!ok) begin
            chk_cnt++;
            $display("FAIL wait_fs: no frame_start in %0d cycles", n);
        end
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        spr_x   = '0;
        spr_y   = '0;
        bg      = 12'h00F;
        rom_key = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({hs1, vs1, bn1, sn1} !== 4'b1100)
            $display("FAIL rst_sync1: got %b want 1100", {hs1, vs1, bn1, sn1});
        else pass_cnt++;
        chk_cnt++;
        if ({r1, g1, b1, r3, g3, b3} !== 48'h0)
            $display("FAIL rst_rgb: got %h want 0", {r1, g1, b1, r3, g3, b3});
        else pass_cnt++;
        chk_cnt++;
        if ({req1, u1, v1, fs1, req3, u3, v3, fs3} !== 16'h0)
            $display("FAIL rst_fetch: got %h want 0",
                     {req1, u1, v1, fs1, req3, u3, v3, fs3});
        else pass_cnt++;
        chk_cnt++;
        if ({hs3, vs3, bn3} !== 3'b110)
            $display("FAIL rst_sync3: got %b want 110", {hs3, vs3, bn3});
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({fs1, fs3} !== 2'b11)
            $display("FAIL first_fs: got %b want 11", {fs1, fs3});
        else pass_cnt++;
    endtask

    task automatic test_timing;
        int hs_lo, vs_lo, bn1_hi, bn3_hi, fs_n, fs_at;
        hs_lo = 0; vs_lo = 0; bn1_hi = 0; bn3_hi = 0;
        fs_n = 0; fs_at = 0;
        wait_fs();
        wait_at(-HB, -VB, 2);
        for (int i = 0; i < FRAME; i++) begin
            if (!hs1) hs_lo++;
            if (!vs1) vs_lo++;
            if (bn1) bn1_hi++;
            if (bn3) bn3_hi++;
            if (fs1) begin
                fs_n++;
                fs_at = cyc;
            end
            @(negedge clk);
        end
        chk_cnt++;
        if (hs_lo !== 112) $display("FAIL hs_low: got %0d want 112", hs_lo);
        else pass_cnt++;
        chk_cnt++;
        if (vs_lo !== 80) $display("FAIL vs_low: got %0d want 80", vs_lo);
        else pass_cnt++;
        chk_cnt++;
        if (bn1_hi !== 768) $display("FAIL blank1: got %0d want 768", bn1_hi);
        else pass_cnt++;
        chk_cnt++;
        if (bn3_hi !== 768) $display("FAIL blank3: got %0d want 768", bn3_hi);
        else pass_cnt++;
        chk_cnt++;
        if (fs_n !== 1) $display("FAIL fs_count: got %0d want 1", fs_n);
        else pass_cnt++;
        wait_fs();
        chk_cnt++;
        if (cyc - fs_at !== FRAME)
            $display("FAIL fs_period: got %0d want %0d", cyc - fs_at, FRAME);
        else pass_cnt++;
    endtask

    task automatic test_sprite_origin;
        spr_x = 10'd0; spr_y = 10'd0; bg = 12'h00F; rom_key = 1'b0;
        wait_fs();
        wait_at(0, 0, 2);
        chk_cnt++;
        if ({r1, g1, b1, bn1} !== {SPR_RGB, 1'b1})
            $display("FAIL org_00: got %h want %h", {r1, g1, b1, bn1}, {SPR_RGB, 1'b1});
        else pass_cnt++;
        wait_at(8, 0, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== BG_RGB)
            $display("FAIL org_80: got %h want %h", {r1, g1, b1}, BG_RGB);
        else pass_cnt++;
        wait_at(7, 7, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== SPR_RGB)
            $display("FAIL org_77: got %h want %h", {r1, g1, b1}, SPR_RGB);
        else pass_cnt++;
        wait_at(7, 7, 4);
        chk_cnt++;
        if ({r3, g3, b3} !== SPR_RGB)
            $display("FAIL org_77_lat3: got %h want %h", {r3, g3, b3}, SPR_RGB);
        else pass_cnt++;
        wait_at(0, 8, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== BG_RGB)
            $display("FAIL org_08: got %h want %h", {r1, g1, b1}, BG_RGB);
        else pass_cnt++;
    endtask

    task automatic test_key;
        rom_key = 1'b1;
        wait_fs();
        wait_at(3, 3, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== BG_RGB)
            $display("FAIL key_33: got %h want %h", {r1, g1, b1}, BG_RGB);
        else pass_cnt++;
        wait_at(7, 7, 0);
        chk_cnt++;
        if ({req1, u1, v1} !== 7'b1_111_111)
            $display("FAIL addr_77: got %b want 1111111", {req1, u1, v1});
        else pass_cnt++;
        wait_at(8, 7, 0);
        chk_cnt++;
        if ({req1, u1, v1} !== 7'b0)
            $display("FAIL addr_87: got %b want 0000000", {req1, u1, v1});
        else pass_cnt++;
        rom_key = 1'b0;
    endtask

    task automatic test_move;
        spr_x = 10'd2; spr_y = 10'd10;
        wait_fs();
        wait_at(0, 5, 2);
        spr_x = 10'd12;
        wait_at(2, 12, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== SPR_RGB)
            $display("FAIL move_old_in: got %h want %h", {r1, g1, b1}, SPR_RGB);
        else pass_cnt++;
        wait_at(12, 12, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== BG_RGB)
            $display("FAIL move_old_out: got %h want %h", {r1, g1, b1}, BG_RGB);
        else pass_cnt++;
        wait_at(2, 12, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== BG_RGB)
            $display("FAIL move_new_out: got %h want %h", {r1, g1, b1}, BG_RGB);
        else pass_cnt++;
        wait_at(12, 12, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== SPR_RGB)
            $display("FAIL move_new_in: got %h want %h", {r1, g1, b1}, SPR_RGB);
        else pass_cnt++;
    endtask

    task automatic test_clip;
        spr_x = 10'd28; spr_y = 10'd20;
        wait_fs();
        wait_at(27, 20, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== BG_RGB)
            $display("FAIL clip_left: got %h want %h", {r1, g1, b1}, BG_RGB);
        else pass_cnt++;
        wait_at(28, 20, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== SPR_RGB)
            $display("FAIL clip_first: got %h want %h", {r1, g1, b1}, SPR_RGB);
        else pass_cnt++;
        wait_at(31, 20, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== SPR_RGB)
            $display("FAIL clip_edge: got %h want %h", {r1, g1, b1}, SPR_RGB);
        else pass_cnt++;
        wait_at(31, 20, 4);
        chk_cnt++;
        if ({r3, g3, b3, bn3} !== {SPR_RGB, 1'b1})
            $display("FAIL clip_edge3: got %h want %h", {r3, g3, b3, bn3}, {SPR_RGB, 1'b1});
        else pass_cnt++;
        wait_at(-8, 21, 4);
        chk_cnt++;
        if ({r3, g3, b3, bn3} !== 25'h0)
            $display("FAIL clip_blank3: got %h want 0", {r3, g3, b3, bn3});
        else pass_cnt++;
        wait_at(0, 21, 0);
        chk_cnt++;
        if (req1 !== 1'b0)
            $display("FAIL clip_nowrap_req: got %b want 0", req1);
        else pass_cnt++;
        wait_at(0, 21, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== BG_RGB)
            $display("FAIL clip_nowrap_px: got %h want %h", {r1, g1, b1}, BG_RGB);
        else pass_cnt++;
        wait_at(31, 23, 2);
        chk_cnt++;
        if ({r1, g1, b1} !== SPR_RGB)
            $display("FAIL clip_corner: got %h want %h", {r1, g1, b1}, SPR_RGB);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        wait_at(10, 5, 0);
        #3 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({hs1, vs1, bn1, hs3, vs3, bn3} !== 6'b110110)
            $display("FAIL mid_rst_sync: got %b want 110110",
                     {hs1, vs1, bn1, hs3, vs3, bn3});
        else pass_cnt++;
        chk_cnt++;
        if ({r1, g1, b1, r3, g3, b3} !== 48'h0)
            $display("FAIL mid_rst_rgb: got %h want 0", {r1, g1, b1, r3, g3, b3});
        else pass_cnt++;
        chk_cnt++;
        if ({req1, u1, v1, fs1, req3, u3, v3, fs3} !== 16'h0)
            $display("FAIL mid_rst_fetch: got %h want 0",
                     {req1, u1, v1, fs1, req3, u3, v3, fs3});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({fs1, fs3} !== 2'b11)
            $display("FAIL mid_restart_fs: got %b want 11", {fs1, fs3});
        else pass_cnt++;
        wait_at(27, 20, 4);
        chk_cnt++;
        if ({r3, g3, b3} !== BG_RGB)
            $display("FAIL mid_left3: got %h want %h", {r3, g3, b3}, BG_RGB);
        else pass_cnt++;
        wait_at(28, 20, 4);
        chk_cnt++;
        if ({r3, g3, b3, bn3} !== {SPR_RGB, 1'b1})
            $display("FAIL mid_first3: got %h want %h", {r3, g3, b3, bn3}, {SPR_RGB, 1'b1});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_sprite_origin();
        test_key();
        test_move();
        test_clip();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
